// File: rtl/us_delay_sched.sv
// us_delay_sched: one prescaled microsecond countdown shared by NREQ requesters.
// Build option: define US_DELAY_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration (default round-robin).

module us_delay_sched #(
  parameter int NREQ = 4,
  parameter int DIV  = 40,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] delay_us,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               tick_1us
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            tick_q, tick_d;

  logic [IW-1:0]   win_idx;
  logic [DW-1:0]   sel_delay;

  assign sel_delay = delay_us[int'(sel_q)*DW +: DW];

`ifdef US_DELAY_SCHED_FIXED_PRIO_EN
  // Scan from the top so the lowest requesting index is the last to overwrite.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IW'(i);
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr_q) + k) % NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = IW'(j);
      end
    end
  end
`endif

  // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    tick_d  = 1'b0;
`ifndef US_DELAY_SCHED_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d        = S_LOAD;
          sel_d          = win_idx;
          gnt_d[win_idx] = 1'b1;
        end
      end

      S_LOAD: begin
        cnt_d = sel_delay;
        pre_d = '0;
`ifndef US_DELAY_SCHED_FIXED_PRIO_EN
        ptr_d = (sel_q == IDX_MAX) ? '0 : sel_q + IW'(1);
`endif
        if (sel_delay == '0) begin
          state_d       = S_DONE;
          done_d[sel_q] = 1'b1;
        end else begin
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        // Withdrawal wins over a coinciding final tick: no tick, no done.
        if (!req[sel_q]) begin
          state_d = S_IDLE;
        end else if (pre_q == PRE_MAX) begin
          pre_d  = '0;
          tick_d = 1'b1;
          cnt_d  = cnt_q - DW'(1);
          if (cnt_q == DW'(1)) begin
            state_d       = S_DONE;
            done_d[sel_q] = 1'b1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
    end
  end

`ifndef US_DELAY_SCHED_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign tick_1us = tick_q;

endmodule
